// File: rtl/tracking_state_pkg.sv
// Shared definitions for the tracking-engine state fill: state word indices,
// bit positions of the packed configuration fields and the fill FSM states.
package tracking_state_pkg;

    localparam int CARRIER_FREQ = 0;
    localparam int CODE_FREQ    = 1;
    localparam int COR_CONFIG   = 2;
    localparam int NH_CONFIG    = 3;
    localparam int COH_CONFIG   = 4;
    localparam int PRN_CONFIG   = 5;
    localparam int PRN_STATE    = 6;
    localparam int PRN_CONFIG2  = 14;
    localparam int PRN2_STATE   = 15;

    // Correlator configuration word
    localparam int PRE_SHIFT_LSB      = 0;
    localparam int ENABLE_BOC_BIT     = 2;
    localparam int DATA_IN_Q_BIT      = 3;
    localparam int ENABLE_2ND_PRN_BIT = 4;
    localparam int NARROW_LSB         = 8;
    localparam int DUMP_LEN_LSB       = 16;

    // NH code word
    localparam int NH_CODE_LSB = 0;
    localparam int NH_LEN_LSB  = 27;

    // Coherent integration word
    localparam int NH_CODE2_LSB   = 0;
    localparam int MS_DATA_LSB    = 20;
    localparam int COH_NUM_LSB    = 25;
    localparam int POST_SHIFT_LSB = 30;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_READ  = 2'd1,
        FILL_DRAIN = 2'd2
    } fill_state_e;

endpackage

// File: rtl/state_rd_pipe.sv
// Valid/index shift register that tracks outstanding state RAM reads so the
// returning data can be tagged with its word index exactly LATENCY cycles later.
module state_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q [LATENCY];
    logic [IDX_W-1:0]   idx_d [LATENCY];

    // A flush drops every in-flight read, including the one issued this cycle.
    always_comb begin
        valid_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            idx_d[i] = '0;
        end
        if (!flush) begin
            valid_d[0] = in_valid;
            idx_d[0]   = in_idx;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                idx_d[i]   = idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/state_fill_sequencer.sv
// Reads every state word of one channel from the state RAM, latches the static
// configuration words and strobes a one-hot load enable for each returned word.
module state_fill_sequencer #(
    parameter int CH_W        = 5,
    parameter int WORD_W      = 5,
    parameter int STATE_WORDS = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     fill_start,
    input  logic [CH_W-1:0]          fill_channel,
    input  logic                     fill_abort,
    output logic                     fill_busy,
    output logic                     fill_done,
    output logic                     state_rd,
    output logic [CH_W+WORD_W-1:0]   state_addr,
    input  logic [31:0]              state_d4rd,
    output logic [STATE_WORDS-1:0]   load_en,
    output logic                     acc_en,
    output logic [31:0]              carrier_freq,
    output logic [31:0]              code_freq,
    output logic [31:0]              prn_config,
    output logic [31:0]              prn2_config,
    output logic [1:0]               pre_shift_bits,
    output logic                     enable_boc,
    output logic                     data_in_q,
    output logic                     enable_2nd_prn,
    output logic [1:0]               narrow_factor,
    output logic [15:0]              dump_length,
    output logic [24:0]              nh_code,
    output logic [4:0]               nh_length,
    output logic [19:0]              nh_code2,
    output logic [4:0]               ms_data_number,
    output logic [4:0]               coherent_number,
    output logic [1:0]               post_shift_bits
);

    import tracking_state_pkg::*;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(STATE_WORDS - 1);

    fill_state_e       state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;

    logic              pipe_valid;
    logic [WORD_W-1:0] pipe_idx;
    logic [STATE_WORDS-1:0] load_en_w;

    logic [31:0] carrier_q, carrier_d;
    logic [31:0] code_q, code_d;
    logic [31:0] prn_q, prn_d;
    logic [31:0] prn2_q, prn2_d;
    logic [1:0]  pre_shift_q, pre_shift_d;
    logic        boc_q, boc_d;
    logic        inq_q, inq_d;
    logic        en2_q, en2_d;
    logic [1:0]  narrow_q, narrow_d;
    logic [15:0] dump_q, dump_d;
    logic [24:0] nh_code_q, nh_code_d;
    logic [4:0]  nh_len_q, nh_len_d;
    logic [19:0] nh_code2_q, nh_code2_d;
    logic [4:0]  ms_q, ms_d;
    logic [4:0]  coh_q, coh_d;
    logic [1:0]  post_shift_q, post_shift_d;

    assign state_rd   = (state_q == FILL_READ);
    assign state_addr = {ch_q, cnt_q};

    state_rd_pipe #(
        .LATENCY (RD_LATENCY),
        .IDX_W   (WORD_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush     (fill_abort),
        .in_valid  (state_rd),
        .in_idx    (cnt_q),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    // Decoded purely from pipeline flops, so at most one bit is ever set.
    always_comb begin
        load_en_w = '0;
        for (int k = 0; k < STATE_WORDS; k++) begin
            load_en_w[k] = pipe_valid && (pipe_idx == WORD_W'(k));
        end
    end

    assign load_en = load_en_w;
    assign acc_en  = load_en_w[STATE_WORDS-1];

    // Abort overrides everything; a start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        if (fill_abort) begin
            state_d = FILL_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                FILL_IDLE: begin
                    if (fill_start) begin
                        state_d = FILL_READ;
                        busy_d  = 1'b1;
                        ch_d    = fill_channel;
                        cnt_d   = '0;
                    end
                end
                FILL_READ: begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = FILL_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FILL_DRAIN: begin
                    if (pipe_valid && (pipe_idx == LAST_WORD)) begin
                        state_d = FILL_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = FILL_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        carrier_d    = carrier_q;
        code_d       = code_q;
        prn_d        = prn_q;
        prn2_d       = prn2_q;
        pre_shift_d  = pre_shift_q;
        boc_d        = boc_q;
        inq_d        = inq_q;
        en2_d        = en2_q;
        narrow_d     = narrow_q;
        dump_d       = dump_q;
        nh_code_d    = nh_code_q;
        nh_len_d     = nh_len_q;
        nh_code2_d   = nh_code2_q;
        ms_d         = ms_q;
        coh_d        = coh_q;
        post_shift_d = post_shift_q;
        if (load_en_w[CARRIER_FREQ]) begin
            carrier_d = state_d4rd;
        end
        if (load_en_w[CODE_FREQ]) begin
            code_d = state_d4rd;
        end
        if (load_en_w[COR_CONFIG]) begin
            pre_shift_d = state_d4rd[PRE_SHIFT_LSB +: 2];
            boc_d       = state_d4rd[ENABLE_BOC_BIT];
            inq_d       = state_d4rd[DATA_IN_Q_BIT];
            en2_d       = state_d4rd[ENABLE_2ND_PRN_BIT];
            narrow_d    = state_d4rd[NARROW_LSB +: 2];
            dump_d      = state_d4rd[DUMP_LEN_LSB +: 16];
        end
        if (load_en_w[NH_CONFIG]) begin
            nh_code_d = state_d4rd[NH_CODE_LSB +: 25];
            nh_len_d  = state_d4rd[NH_LEN_LSB +: 5];
        end
        if (load_en_w[COH_CONFIG]) begin
            nh_code2_d   = state_d4rd[NH_CODE2_LSB +: 20];
            ms_d         = state_d4rd[MS_DATA_LSB +: 5];
            coh_d        = state_d4rd[COH_NUM_LSB +: 5];
            post_shift_d = state_d4rd[POST_SHIFT_LSB +: 2];
        end
        if (load_en_w[PRN_CONFIG]) begin
            prn_d = state_d4rd;
        end
        if (load_en_w[PRN_CONFIG2]) begin
            prn2_d = state_d4rd;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= FILL_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ch_q         <= '0;
            cnt_q        <= '0;
            carrier_q    <= '0;
            code_q       <= '0;
            prn_q        <= '0;
            prn2_q       <= '0;
            pre_shift_q  <= '0;
            boc_q        <= 1'b0;
            inq_q        <= 1'b0;
            en2_q        <= 1'b0;
            narrow_q     <= '0;
            dump_q       <= '0;
            nh_code_q    <= '0;
            nh_len_q     <= '0;
            nh_code2_q   <= '0;
            ms_q         <= '0;
            coh_q        <= '0;
            post_shift_q <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            carrier_q    <= carrier_d;
            code_q       <= code_d;
            prn_q        <= prn_d;
            prn2_q       <= prn2_d;
            pre_shift_q  <= pre_shift_d;
            boc_q        <= boc_d;
            inq_q        <= inq_d;
            en2_q        <= en2_d;
            narrow_q     <= narrow_d;
            dump_q       <= dump_d;
            nh_code_q    <= nh_code_d;
            nh_len_q     <= nh_len_d;
            nh_code2_q   <= nh_code2_d;
            ms_q         <= ms_d;
            coh_q        <= coh_d;
            post_shift_q <= post_shift_d;
        end
    end

    assign fill_busy       = busy_q;
    assign fill_done       = done_q;
    assign carrier_freq    = carrier_q;
    assign code_freq       = code_q;
    assign prn_config      = prn_q;
    assign prn2_config     = prn2_q;
    assign pre_shift_bits  = pre_shift_q;
    assign enable_boc      = boc_q;
    assign data_in_q       = inq_q;
    assign enable_2nd_prn  = en2_q;
    assign narrow_factor   = narrow_q;
    assign dump_length     = dump_q;
    assign nh_code         = nh_code_q;
    assign nh_length       = nh_len_q;
    assign nh_code2        = nh_code2_q;
    assign ms_data_number  = ms_q;
    assign coherent_number = coh_q;
    assign post_shift_bits = post_shift_q;

endmodule

// File: tb/tb_state_fill_sequencer.sv
// Directed bench for the state fill sequencer: three instances cover the default
// configuration, a 3-cycle RAM read latency and a 20-word channel.
module tb_state_fill_sequencer;

    logic clk = 1'b0;
    logic rst_b;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    // Default instance: RD_LATENCY=1, STATE_WORDS=16
    logic        fill_start, fill_abort, fill_busy, fill_done, state_rd, acc_en;
    logic [4:0]  fill_channel;
    logic [9:0]  state_addr;
    logic [31:0] state_d4rd;
    logic [15:0] load_en;
    logic [31:0] carrier_freq, code_freq, prn_config, prn2_config;
    logic [1:0]  pre_shift_bits, narrow_factor, post_shift_bits;
    logic        enable_boc, data_in_q, enable_2nd_prn;
    logic [15:0] dump_length;
    logic [24:0] nh_code;
    logic [4:0]  nh_length, ms_data_number, coherent_number;
    logic [19:0] nh_code2;

    state_fill_sequencer dut (
        .clk(clk), .rst_b(rst_b), .fill_start(fill_start), .fill_channel(fill_channel),
        .fill_abort(fill_abort), .fill_busy(fill_busy), .fill_done(fill_done),
        .state_rd(state_rd), .state_addr(state_addr), .state_d4rd(state_d4rd),
        .load_en(load_en), .acc_en(acc_en), .carrier_freq(carrier_freq),
        .code_freq(code_freq), .prn_config(prn_config), .prn2_config(prn2_config),
        .pre_shift_bits(pre_shift_bits), .enable_boc(enable_boc), .data_in_q(data_in_q),
        .enable_2nd_prn(enable_2nd_prn), .narrow_factor(narrow_factor),
        .dump_length(dump_length), .nh_code(nh_code), .nh_length(nh_length),
        .nh_code2(nh_code2), .ms_data_number(ms_data_number),
        .coherent_number(coherent_number), .post_shift_bits(post_shift_bits)
    );

    // RAM: 0x1000 + word, with channel 3 mapping to exactly 0x1000 + word
    function automatic logic [31:0] ram_word(input logic [9:0] addr);
        return 32'h1000 + 32'(addr[4:0]) + (32'(addr[9:5] ^ 5'd3) << 8);
    endfunction

    always @(posedge clk) state_d4rd <= ram_word(state_addr);

    // Latency-3 instance
    logic        l3_fill_start, l3_fill_abort, l3_fill_busy, l3_fill_done, l3_state_rd, l3_acc_en;
    logic [4:0]  l3_fill_channel;
    logic [9:0]  l3_state_addr;
    logic [31:0] l3_state_d4rd, l3_p1, l3_p2;
    logic [15:0] l3_load_en;
    logic [31:0] l3_carrier_freq, l3_code_freq, l3_prn_config, l3_prn2_config;
    logic [1:0]  l3_pre_shift_bits, l3_narrow_factor, l3_post_shift_bits;
    logic        l3_enable_boc, l3_data_in_q, l3_enable_2nd_prn;
    logic [15:0] l3_dump_length;
    logic [24:0] l3_nh_code;
    logic [4:0]  l3_nh_length, l3_ms_data_number, l3_coherent_number;
    logic [19:0] l3_nh_code2;

    state_fill_sequencer #(.RD_LATENCY(3)) dut_l3 (
        .clk(clk), .rst_b(rst_b), .fill_start(l3_fill_start), .fill_channel(l3_fill_channel),
        .fill_abort(l3_fill_abort), .fill_busy(l3_fill_busy), .fill_done(l3_fill_done),
        .state_rd(l3_state_rd), .state_addr(l3_state_addr), .state_d4rd(l3_state_d4rd),
        .load_en(l3_load_en), .acc_en(l3_acc_en), .carrier_freq(l3_carrier_freq),
        .code_freq(l3_code_freq), .prn_config(l3_prn_config), .prn2_config(l3_prn2_config),
        .pre_shift_bits(l3_pre_shift_bits), .enable_boc(l3_enable_boc), .data_in_q(l3_data_in_q),
        .enable_2nd_prn(l3_enable_2nd_prn), .narrow_factor(l3_narrow_factor),
        .dump_length(l3_dump_length), .nh_code(l3_nh_code), .nh_length(l3_nh_length),
        .nh_code2(l3_nh_code2), .ms_data_number(l3_ms_data_number),
        .coherent_number(l3_coherent_number), .post_shift_bits(l3_post_shift_bits)
    );

    function automatic logic [31:0] l3_word(input logic [9:0] addr);
        return (addr[4:0] == 5'd2) ? 32'hABCD_031F : 32'h3000 + 32'(addr[4:0]);
    endfunction

    always @(posedge clk) begin
        l3_p1         <= l3_word(l3_state_addr);
        l3_p2         <= l3_p1;
        l3_state_d4rd <= l3_p2;
    end

    // 20-word instance
    logic        w20_fill_start, w20_fill_abort, w20_fill_busy, w20_fill_done, w20_state_rd, w20_acc_en;
    logic [4:0]  w20_fill_channel;
    logic [9:0]  w20_state_addr;
    logic [31:0] w20_state_d4rd;
    logic [19:0] w20_load_en;
    logic [31:0] w20_carrier_freq, w20_code_freq, w20_prn_config, w20_prn2_config;
    logic [1:0]  w20_pre_shift_bits, w20_narrow_factor, w20_post_shift_bits;
    logic        w20_enable_boc, w20_data_in_q, w20_enable_2nd_prn;
    logic [15:0] w20_dump_length;
    logic [24:0] w20_nh_code;
    logic [4:0]  w20_nh_length, w20_ms_data_number, w20_coherent_number;
    logic [19:0] w20_nh_code2;

    state_fill_sequencer #(.STATE_WORDS(20)) dut_w20 (
        .clk(clk), .rst_b(rst_b), .fill_start(w20_fill_start), .fill_channel(w20_fill_channel),
        .fill_abort(w20_fill_abort), .fill_busy(w20_fill_busy), .fill_done(w20_fill_done),
        .state_rd(w20_state_rd), .state_addr(w20_state_addr), .state_d4rd(w20_state_d4rd),
        .load_en(w20_load_en), .acc_en(w20_acc_en), .carrier_freq(w20_carrier_freq),
        .code_freq(w20_code_freq), .prn_config(w20_prn_config), .prn2_config(w20_prn2_config),
        .pre_shift_bits(w20_pre_shift_bits), .enable_boc(w20_enable_boc), .data_in_q(w20_data_in_q),
        .enable_2nd_prn(w20_enable_2nd_prn), .narrow_factor(w20_narrow_factor),
        .dump_length(w20_dump_length), .nh_code(w20_nh_code), .nh_length(w20_nh_length),
        .nh_code2(w20_nh_code2), .ms_data_number(w20_ms_data_number),
        .coherent_number(w20_coherent_number), .post_shift_bits(w20_post_shift_bits)
    );

    always @(posedge clk) w20_state_d4rd <= 32'h2000 + 32'(w20_state_addr[4:0]);

    task automatic test_reset();
        rst_b = 1'b0;
        fill_start = 0; fill_abort = 0; fill_channel = '0;
        l3_fill_start = 0; l3_fill_abort = 0; l3_fill_channel = '0;
        w20_fill_start = 0; w20_fill_abort = 0; w20_fill_channel = '0;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({fill_busy, fill_done, state_rd, acc_en} !== 4'b0)
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {fill_busy, fill_done, state_rd, acc_en});
        else pass_cnt++;
        check_cnt++;
        if (state_addr !== 10'h0 || load_en !== 16'h0)
            $display("[TB] FAIL reset_addr_load: got %h/%h expected 0/0", state_addr, load_en);
        else pass_cnt++;
        check_cnt++;
        if (carrier_freq !== 0 || prn2_config !== 0 || dump_length !== 0 || nh_code !== 0)
            $display("[TB] FAIL reset_config: got %h %h %h %h expected zeros", carrier_freq, prn2_config, dump_length, nh_code);
        else pass_cnt++;
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        logic [15:0] exp_le;
        fill_channel = 5'd3; fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            exp_le = '0;
            if (c >= 2 && c <= 17) exp_le[c-2] = 1'b1;
            check_cnt++;
            if (state_rd !== (c <= 16))
                $display("[TB] FAIL basic_rd c=%0d: got %b expected %b", c, state_rd, (c <= 16));
            else pass_cnt++;
            if (c <= 16) begin
                check_cnt++;
                if (state_addr !== {5'd3, 5'(c-1)})
                    $display("[TB] FAIL basic_addr c=%0d: got %h expected %h", c, state_addr, {5'd3, 5'(c-1)});
                else pass_cnt++;
            end
            check_cnt++;
            if (load_en !== exp_le || acc_en !== (c == 17))
                $display("[TB] FAIL basic_load c=%0d: got %h/%b expected %h/%b", c, load_en, acc_en, exp_le, (c == 17));
            else pass_cnt++;
            check_cnt++;
            if (fill_done !== (c == 18) || fill_busy !== (c <= 17))
                $display("[TB] FAIL basic_done_busy c=%0d: got %b/%b expected %b/%b", c, fill_done, fill_busy, (c == 18), (c <= 17));
            else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++;
        if (carrier_freq !== 32'h1000 || code_freq !== 32'h1001 || prn_config !== 32'h1005 || prn2_config !== 32'h100E)
            $display("[TB] FAIL basic_words: got %h %h %h %h expected 1000 1001 1005 100e", carrier_freq, code_freq, prn_config, prn2_config);
        else pass_cnt++;
        check_cnt++;
        if (pre_shift_bits !== 2'd2 || nh_code !== 25'h1003 || nh_code2 !== 20'h01004 || dump_length !== 16'h0)
            $display("[TB] FAIL basic_fields: got %h %h %h %h expected 2 1003 1004 0", pre_shift_bits, nh_code, nh_code2, dump_length);
        else pass_cnt++;
    endtask

    task automatic test_latency3();
        logic [15:0] exp_le;
        l3_fill_channel = 5'd4; l3_fill_start = 1'b1;
        @(negedge clk);
        l3_fill_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            exp_le = '0;
            if (c >= 4 && c <= 19) exp_le[c-4] = 1'b1;
            check_cnt++;
            if (l3_state_rd !== (c <= 16) || l3_load_en !== exp_le)
                $display("[TB] FAIL l3_rd_load c=%0d: got %b/%h expected %b/%h", c, l3_state_rd, l3_load_en, (c <= 16), exp_le);
            else pass_cnt++;
            check_cnt++;
            if (l3_fill_done !== (c == 20) || l3_fill_busy !== (c <= 19))
                $display("[TB] FAIL l3_done_busy c=%0d: got %b/%b expected %b/%b", c, l3_fill_done, l3_fill_busy, (c == 20), (c <= 19));
            else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++;
        if ({l3_pre_shift_bits, l3_enable_boc, l3_data_in_q, l3_enable_2nd_prn, l3_narrow_factor} !== 7'b11_1_1_1_11)
            $display("[TB] FAIL l3_cor_bits: got %b expected 1111111", {l3_pre_shift_bits, l3_enable_boc, l3_data_in_q, l3_enable_2nd_prn, l3_narrow_factor});
        else pass_cnt++;
        check_cnt++;
        if (l3_dump_length !== 16'hABCD || l3_carrier_freq !== 32'h3000)
            $display("[TB] FAIL l3_dump_carrier: got %h/%h expected abcd/3000", l3_dump_length, l3_carrier_freq);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        fill_channel = 5'd5; fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_cnt++;
            if (state_rd !== 1'b1)
                $display("[TB] FAIL abort_pre_rd c=%0d: got %b expected 1", c, state_rd);
            else pass_cnt++;
            if (c == 8) fill_abort = 1'b1;
            @(negedge clk);
        end
        fill_abort = 1'b0;
        check_cnt++;
        if (state_rd !== 1'b0 || fill_busy !== 1'b0 || load_en !== 16'h0)
            $display("[TB] FAIL abort_next: got rd=%b busy=%b le=%h expected 0/0/0", state_rd, fill_busy, load_en);
        else pass_cnt++;
        for (int c = 0; c < 12; c++) begin
            check_cnt++;
            if (load_en !== 16'h0 || fill_done !== 1'b0 || state_rd !== 1'b0)
                $display("[TB] FAIL abort_quiet c=%0d: got le=%h done=%b rd=%b expected 0", c, load_en, fill_done, state_rd);
            else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++;
        if (carrier_freq !== 32'h1600 || code_freq !== 32'h1601 || prn_config !== 32'h1605 || nh_code !== 25'h1603)
            $display("[TB] FAIL abort_kept: got %h %h %h %h expected 1600 1601 1605 1603", carrier_freq, code_freq, prn_config, nh_code);
        else pass_cnt++;
        check_cnt++;
        if (prn2_config !== 32'h100E)
            $display("[TB] FAIL abort_prn2: got %h expected 100e", prn2_config);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit seen_done = 0;
        fill_channel = 5'd1; fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16) begin
                check_cnt++;
                if (state_addr !== {5'd1, 5'(c-1)})
                    $display("[TB] FAIL b2b_addr1 c=%0d: got %h expected %h", c, state_addr, {5'd1, 5'(c-1)});
                else pass_cnt++;
            end
            check_cnt++;
            if (fill_done !== (c == 18) || fill_busy !== (c <= 17))
                $display("[TB] FAIL b2b_done1 c=%0d: got %b/%b expected %b/%b", c, fill_done, fill_busy, (c == 18), (c <= 17));
            else pass_cnt++;
            fill_start   = (c == 5 || c == 17 || c == 18);
            fill_channel = (c == 18) ? 5'd2 : 5'd7;
            @(negedge clk);
        end
        fill_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check_cnt++;
            if (state_rd !== 1'b1 || state_addr !== {5'd2, 5'(c-1)})
                $display("[TB] FAIL b2b_addr2 c=%0d: got %b/%h expected 1/%h", c, state_rd, state_addr, {5'd2, 5'(c-1)});
            else pass_cnt++;
            @(negedge clk);
        end
        for (int c = 0; c < 10 && !seen_done; c++) begin
            if (fill_done === 1'b1) seen_done = 1;
            else @(negedge clk);
        end
        check_cnt++;
        if (!seen_done)
            $display("[TB] FAIL b2b_done2: got no fill_done expected one within 10 cycles");
        else pass_cnt++;
        check_cnt++;
        if (carrier_freq !== 32'h1100 || prn2_config !== 32'h110E)
            $display("[TB] FAIL b2b_words: got %h/%h expected 1100/110e", carrier_freq, prn2_config);
        else pass_cnt++;
    endtask

    task automatic test_words20();
        logic [19:0] exp_le;
        w20_fill_channel = 5'd9; w20_fill_start = 1'b1;
        @(negedge clk);
        w20_fill_start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            exp_le = '0;
            if (c >= 2 && c <= 21) exp_le[c-2] = 1'b1;
            check_cnt++;
            if (w20_state_rd !== (c <= 20) || w20_load_en !== exp_le)
                $display("[TB] FAIL w20_rd_load c=%0d: got %b/%h expected %b/%h", c, w20_state_rd, w20_load_en, (c <= 20), exp_le);
            else pass_cnt++;
            check_cnt++;
            if (w20_acc_en !== (c == 21) || w20_fill_done !== (c == 22))
                $display("[TB] FAIL w20_acc_done c=%0d: got %b/%b expected %b/%b", c, w20_acc_en, w20_fill_done, (c == 21), (c == 22));
            else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++;
        if (w20_carrier_freq !== 32'h2000 || w20_prn2_config !== 32'h200E || w20_prn_config !== 32'h2005)
            $display("[TB] FAIL w20_words: got %h %h %h expected 2000 200e 2005", w20_carrier_freq, w20_prn2_config, w20_prn_config);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        fill_channel = 5'd3; fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        repeat (4) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_cnt++;
        if (state_rd !== 1'b0 || fill_busy !== 1'b0 || load_en !== 16'h0 || state_addr !== 10'h0)
            $display("[TB] FAIL rst_mid_ctrl: got rd=%b busy=%b le=%h addr=%h expected 0", state_rd, fill_busy, load_en, state_addr);
        else pass_cnt++;
        check_cnt++;
        if (carrier_freq !== 0 || prn2_config !== 0 || l3_dump_length !== 0 || w20_carrier_freq !== 0)
            $display("[TB] FAIL rst_mid_config: got %h %h %h %h expected zeros", carrier_freq, prn2_config, l3_dump_length, w20_carrier_freq);
        else pass_cnt++;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        test_basic_fill();
    endtask

    initial begin
        $display("[TB] state_fill_sequencer directed tests");
        test_reset();
        test_basic_fill();
        test_latency3();
        test_abort();
        test_back_to_back();
        test_words20();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
